// File: rtl/instruction_encoder_if.sv
// Bus interface for instruction_encoder.
// Groups the input field handshake, the output word stream and the
// reject status into one bundle. clk, rst_n and clear stay as plain
// ports on the encoder.
//   master : producer/consumer side (drives fields, in_valid, out_ready)
//   slave  : encoder side (drives in_ready, out_*, err, err_count)
interface instruction_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [7:0]        err_count;

  modport master (
    output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_count
  );

  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_count
  );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder
// Packs decoded RV32I fields plus a signed 32-bit immediate into an
// instruction word, buffers words in a DEPTH-entry FIFO and streams them
// out tagged with incrementing word addresses (step 4). Inputs whose
// immediate is out of range or misaligned, or whose opcode is unsupported,
// are consumed but rejected: err pulses and err_count saturates at 255.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous flush of FIFO and address counter (err_count kept)
//   bus    : instruction_encoder_if.slave (in_valid/in_ready, opcode, rd,
//            rs1, rs2, funct3, funct7, imm, out_valid/out_ready, out_instr,
//            out_addr, err, err_count)
//
// Optional feature: define ENC_UTYPE_EN to encode LUI/AUIPC; otherwise
// those opcodes are rejected.
module instruction_encoder #(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  instruction_encoder_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_JALR   = 7'b1100111,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_cnt;
  logic              err_q;
  logic [7:0]        err_cnt_q;

  logic [31:0] word;
  logic        legal;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic        accept;
  logic        push;
  logic        pop;
  logic        reject;
  logic [31:0] imm;

  assign imm = bus.imm;

  // Range checks: the immediate fits N signed bits when every bit above
  // bit N-1 equals the sign bit.
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (opcode_e'(bus.opcode))
      OP_LOAD, OP_IMM, OP_JALR: begin
        word  = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        legal = fits12;
      end
      OP_STORE: begin
        word  = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
        legal = fits12;
      end
      OP_BRANCH: begin
        word  = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                 imm[4:1], imm[11], bus.opcode};
        legal = fits13 & ~imm[0];
      end
      OP_JAL: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
        legal = fits21 & ~imm[0];
      end
      OP_REG: begin
        word  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        legal = 1'b1;
      end
`ifdef ENC_UTYPE_EN
      OP_LUI, OP_AUIPC: begin
        word  = {imm[31:12], bus.rd, bus.opcode};
        legal = ~(|imm[11:0]);
      end
`endif
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign bus.in_ready = (count < CNT_FULL);
  assign accept       = bus.in_valid & bus.in_ready;
  // clear overrides push, pop and reject alike.
  assign push         = accept & legal & ~clear;
  assign reject       = accept & ~legal & ~clear;
  assign pop          = bus.out_valid & bus.out_ready & ~clear;

  assign bus.out_valid = (count != '0);
  assign bus.out_instr = bus.out_valid ? instr_mem[head] : '0;
  assign bus.out_addr  = bus.out_valid ? addr_mem[head]  : '0;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;

  // Storage is gated by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= word;
      addr_mem[tail]  <= addr_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      addr_cnt <= BASE_ADDR;
    end else if (clear) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      addr_cnt <= BASE_ADDR;
    end else begin
      if (push) begin
        tail     <= tail + PTR_W'(1);
        addr_cnt <= addr_cnt + ADDR_W'(4);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= reject;
      if (reject && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

endmodule
